// File: rtl/fwd_ctrl_pkg.sv
// Shared constants for the forwarding / load-use hazard controller.
package fwd_ctrl_pkg;

  localparam logic RstEnable = 1'b1;

  typedef enum logic [1:0] {
    FwdRegFile = 2'b00,
    FwdExeMem  = 2'b01,
    FwdMemWb   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one source register, from the EX/MEM shadow stages.
module fwd_sel
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  used,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output fwd_sel_e              sel
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = ex_valid & ex_reg_write & (ex_rd == rs) & (rs != '0);
  assign hit_mem = mem_valid & mem_reg_write & (mem_rd == rs) & (rs != '0);

  // The EX-resident producer is younger than the MEM one, so it wins.
  always_comb begin
    sel = FwdRegFile;
    if (used && hit_ex) begin
      sel = FwdExeMem;
    end else if (used && hit_mem) begin
      sel = FwdMemWb;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select and load-use stall controller for the 5-stage core.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  flush_i,
  output logic [1:0]            forwarding_rs1_o,
  output logic [1:0]            forwarding_rs2_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  advance;
  fwd_sel_e              sel_rs1;
  fwd_sel_e              sel_rs2;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_rs1 (
    .rs            (id_rs1_i),
    .used          (id_rs1_used_i),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (sel_rs1)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_rs2 (
    .rs            (id_rs2_i),
    .used          (id_rs2_used_i),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .sel           (sel_rs2)
  );

  // A load in EX cannot feed the ID consumer in time; a flush overrides the stall.
  assign stall_o = id_valid_i & ~flush_i & ex_valid & ex_mem_read & (ex_rd != '0) &
                   ((id_rs1_used_i & (ex_rd == id_rs1_i)) |
                    (id_rs2_used_i & (ex_rd == id_rs2_i)));

  assign advance = id_valid_i & ~stall_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEnable) begin
      ex_valid         <= 1'b0;
      ex_rd            <= '0;
      ex_reg_write     <= 1'b0;
      ex_mem_read      <= 1'b0;
      mem_valid        <= 1'b0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      forwarding_rs1_o <= FwdRegFile;
      forwarding_rs2_o <= FwdRegFile;
      stall_cnt_o      <= '0;
    end else begin
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (advance) begin
        ex_valid         <= 1'b1;
        ex_rd            <= id_rd_i;
        ex_reg_write     <= id_reg_write_i;
        ex_mem_read      <= id_mem_read_i;
        forwarding_rs1_o <= sel_rs1;
        forwarding_rs2_o <= sel_rs2;
      end else begin
        ex_valid         <= 1'b0;
        ex_rd            <= '0;
        ex_reg_write     <= 1'b0;
        ex_mem_read      <= 1'b0;
        forwarding_rs1_o <= FwdRegFile;
        forwarding_rs2_o <= FwdRegFile;
      end
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed instruction sequences with hand-computed responses.
module tb_fwd_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  typedef struct {
    logic [1:0]    f1;
    logic [1:0]    f2;
    logic          stall;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          id_valid_i = 1'b0;
  logic [RW-1:0] id_rs1_i = '0;
  logic [RW-1:0] id_rs2_i = '0;
  logic          id_rs1_used_i = 1'b0;
  logic          id_rs2_used_i = 1'b0;
  logic [RW-1:0] id_rd_i = '0;
  logic          id_reg_write_i = 1'b0;
  logic          id_mem_read_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [1:0]    forwarding_rs1_o;
  logic [1:0]    forwarding_rs2_o;
  logic          stall_o;
  logic [CW-1:0] stall_cnt_o;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  fwd_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .id_rd_i          (id_rd_i),
    .id_reg_write_i   (id_reg_write_i),
    .id_mem_read_i    (id_mem_read_i),
    .flush_i          (flush_i),
    .forwarding_rs1_o (forwarding_rs1_o),
    .forwarding_rs2_o (forwarding_rs2_o),
    .stall_o          (stall_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input exp_t e);
    checks++;
    if (forwarding_rs1_o !== e.f1) begin
      errors++;
      $display("[TB] FAIL %s.fwd1 got %0d want %0d", e.name, forwarding_rs1_o, e.f1);
    end
    checks++;
    if (forwarding_rs2_o !== e.f2) begin
      errors++;
      $display("[TB] FAIL %s.fwd2 got %0d want %0d", e.name, forwarding_rs2_o, e.f2);
    end
    checks++;
    if (stall_o !== e.stall) begin
      errors++;
      $display("[TB] FAIL %s.stall got %0d want %0d", e.name, stall_o, e.stall);
    end
    checks++;
    if (stall_cnt_o !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s.cnt got %0d want %0d", e.name, stall_cnt_o, e.cnt);
    end
  endtask

  task automatic driveId(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [RW-1:0] rd,
                         input logic rw, input logic mr, input logic fl);
    id_valid_i     = v;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    id_rs1_used_i  = u1;
    id_rs2_used_i  = u2;
    id_rd_i        = rd;
    id_reg_write_i = rw;
    id_mem_read_i  = mr;
    flush_i        = fl;
  endtask

  // Each call is one cycle: ID contents plus what the DUT must show mid-cycle.
  task automatic applyStimulus(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                               input logic u1, input logic u2, input logic [RW-1:0] rd,
                               input logic rw, input logic mr, input logic fl,
                               input logic [1:0] e1, input logic [1:0] e2, input logic es,
                               input logic [CW-1:0] ec, input string name);
    exp_t e;
    @(posedge clk_i);
    #1;
    driveId(v, rs1, rs2, u1, u2, rd, rw, mr, fl);
    e.f1 = e1; e.f2 = e2; e.stall = es; e.cnt = ec; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic nopCycle(input logic [1:0] e1, input logic [1:0] e2, input logic [CW-1:0] ec,
                          input string name);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e2, 1'b0, ec, name);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    exp_t e;
    logic [CW-1:0] ca;
    logic [CW-1:0] cc;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    nopCycle(2'd0, 2'd0, 4'd0, "reset_state");
    // add x5,x1,x2 ; sub x6,x5,x3
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, "ex_add");
    applyStimulus(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, "ex_sub_id");
    nopCycle(2'd1, 2'd0, 4'd0, "ex_fwd");
    // add x5 ; nop ; or x7,x4,x5
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, "mem_add");
    nopCycle(2'd0, 2'd0, 4'd0, "mem_gap");
    applyStimulus(1, 5'd4, 5'd5, 1, 1, 5'd7, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, "mem_or_id");
    nopCycle(2'd0, 2'd2, 4'd0, "mem_fwd");
    // lw x8 ; and x9,x8,x8
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'd0, 2'd0, 0, 4'd0, "lu_lw");
    applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'd0, 2'd0, 1, 4'd0, "lu_stall");
    applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "lu_held");
    nopCycle(2'd2, 2'd2, 4'd1, "lu_fwd");
    // add x5 ; add x5 ; sub x6,x5,x5
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "pri_add1");
    applyStimulus(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "pri_add2");
    applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "pri_sub_id");
    nopCycle(2'd1, 2'd1, 4'd1, "pri_fwd");
    // lw x0 ; consumer of x0
    applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 1, 0, 2'd0, 2'd0, 0, 4'd1, "x0_lw");
    applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd10, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "x0_nostall");
    nopCycle(2'd0, 2'd0, 4'd1, "x0_fwd");
    // lw x8 ; flushed consumer
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'd0, 2'd0, 0, 4'd1, "fl_lw");
    applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 1, 2'd0, 2'd0, 0, 4'd1, "fl_nostall");
    nopCycle(2'd0, 2'd0, 4'd1, "fl_bubble");
    // lw x8 ; immediate op with rs2 field = x8 but unused
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'd0, 2'd0, 0, 4'd1, "imm_lw");
    applyStimulus(1, 5'd3, 5'd8, 1, 0, 5'd9, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "imm_nostall");
    nopCycle(2'd0, 2'd0, 4'd1, "imm_fwd");
    // lw x10 ; lw x11 ; add x12,x10,x0
    applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd10, 1, 1, 0, 2'd0, 2'd0, 0, 4'd1, "bb_lw10");
    applyStimulus(1, 5'd2, 5'd0, 1, 0, 5'd11, 1, 1, 0, 2'd0, 2'd0, 0, 4'd1, "bb_lw11");
    applyStimulus(1, 5'd10, 5'd0, 1, 1, 5'd12, 1, 0, 0, 2'd0, 2'd0, 0, 4'd1, "bb_nostall");
    nopCycle(2'd2, 2'd0, 4'd1, "bb_fwd");
    // Repeated load-use pairs drive the counter into saturation.
    for (int j = 0; j < 16; j++) begin
      ca = (j + 1 > 15) ? 4'd15 : CW'(j + 1);
      cc = (j + 2 > 15) ? 4'd15 : CW'(j + 2);
      applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, (j == 0) ? 2'd0 : 2'd2,
                    (j == 0) ? 2'd0 : 2'd2, 0, ca, "sat_lw");
      applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'd0, 2'd0, 1, ca, "sat_stall");
      applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'd0, 2'd0, 0, cc, "sat_held");
    end
    // lw x8,0(x9) right behind and x9 gets select 01, then a load-use stall
    applyStimulus(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0, 2'd2, 2'd2, 0, 4'd15, "rst_lw");
    @(posedge clk_i);
    #1;
    driveId(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0);
    #1;
    e.f1 = 2'd1; e.f2 = 2'd0; e.stall = 1'b1; e.cnt = 4'd15; e.name = "rst_pre";
    checkOutput(e);
    rst_i = 1'b1;
    #1;
    e.f1 = 2'd0; e.f2 = 2'd0; e.stall = 1'b0; e.cnt = 4'd0; e.name = "rst_async";
    checkOutput(e);
    @(posedge clk_i);
    #1;
    driveId(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    rst_i = 1'b0;
    applyStimulus(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 2'd0, 2'd0, 0, 4'd0, "post_rst_id");
    nopCycle(2'd0, 2'd0, 4'd0, "post_rst_fwd");

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk_i);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
